// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int WAIT_W = 4;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Naturally aligned byte, halfword or word lane pattern for byte offset a.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] a);
        logic [3:0] byte_m;
        logic [3:0] half_m;
        byte_m = BE_BYTE << a;
        half_m = BE_HALF << a;
        return (be == byte_m) || (!a[0] && (be == half_m)) || ((a == 2'd0) && (be == BE_WORD));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte-lane writes and a registered read.
// The storage itself is never reset; only the read register is.
module dmem_array #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [XLEN-1:0]  wdata,
    input  logic             rd_zero,
    output logic [XLEN-1:0]  rdata
);
    localparam int LANE_W = XLEN / 4;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] rdata_d;

    // Byte-lane write; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read data for the access; stores and rejected accesses return zero.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = rd_zero ? '0 : mem_q[idx];
        end
    end

    // Read register holds its value between accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core's load/store port. One request at a time,
// WAIT_STATES extra cycles, then a single-cycle response.
// Build option DMEM_ERR_CHECK_EN: flag out-of-range addresses and misaligned
// lane patterns with rsp_err, suppressing the store and zeroing read data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [3:0]      req_be,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              go;
    logic              acc_we;
    logic              acc_err;
    logic [3:0]        acc_be;
    logic [XLEN-1:0]   acc_addr;
    logic [XLEN-1:0]   acc_wdata;

    assign req_ready = (state_q != WAIT);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;

    // Access operands: latched copy after waiting, live inputs when the access lands on the accept edge.
    always_comb begin
        if (state_q == WAIT) begin
            acc_we    = we_q;
            acc_be    = be_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end else begin
            acc_we    = req_we;
            acc_be    = req_be;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    // Reject addresses beyond the array and lane patterns that are not naturally aligned.
    always_comb begin
        acc_err = ((acc_addr >> (IDX_W + 2)) != '0) || !be_legal(acc_be, acc_addr[1:0]);
    end
`else
    // Without checking, upper address bits alias and byte offset is ignored.
    logic unused_acc_addr;
    assign acc_err         = 1'b0;
    assign unused_acc_addr = ^acc_addr;
`endif

    // Next-state, wait counter and request capture; go marks the edge entering RESP.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        go         = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    we_d       = req_we;
                    be_d       = req_be;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    wait_cnt_d = WAIT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        go      = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                if (wait_cnt_q == WAIT_W'(1)) begin
                    state_d = RESP;
                    go      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = go ? acc_err : err_q;
    end

    // State and captured-request registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    dmem_array #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .en      (go),
        .we      (acc_we && !acc_err),
        .be      (acc_be),
        .idx     (acc_addr[IDX_W+1:2]),
        .wdata   (acc_wdata),
        .rd_zero (acc_we || acc_err),
        .rdata   (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states, one with three.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid0, req_valid3;
    logic        req_ready0, req_ready3;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid0, rsp_valid3;
    logic [31:0] rsp_rdata0, rsp_rdata3;
    logic        rsp_err0, rsp_err3;

    int checks   = 0;
    int failures = 0;

    logic [32:0] q0[$];
    logic [32:0] q3[$];
    logic [31:0] m0[int];
    logic [31:0] m3[int];

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid3),
        .rsp_rdata (rsp_rdata3),
        .rsp_err   (rsp_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: got %h, want %h", tag, obs, want);
        end
    endtask

    // Drive a request to one instance and push its expected response.
    task automatic req(input int d, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd, input logic err);
        int          idx;
        logic [31:0] word;
        logic [31:0] want;
        idx = int'(addr[11:2]);
        if (d == 0) word = m0.exists(idx) ? m0[idx] : 32'h0;
        else        word = m3.exists(idx) ? m3[idx] : 32'h0;
        want = 32'h0;
        if (we) begin
            if (!err) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) word[i*8 +: 8] = wd[i*8 +: 8];
                end
            end
        end else if (!err) begin
            want = word;
        end
        if (d == 0) begin
            m0[idx] = word;
            q0.push_back({err, want});
        end else begin
            m3[idx] = word;
            q3.push_back({err, want});
        end
        req_we     = we;
        req_be     = be;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid0 = (d == 0);
        req_valid3 = (d != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
    endtask

    // Scoreboard: every response pulse pops and compares the oldest expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rsp_valid0) begin
            check("rsp0_expected", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("rsp0_rdata", rsp_rdata0, e[31:0]);
                check("rsp0_err", 32'(rsp_err0), 32'(e[32]));
            end
        end
        if (rsp_valid3) begin
            check("rsp3_expected", 32'(q3.size() > 0), 32'd1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("rsp3_rdata", rsp_rdata3, e[31:0]);
                check("rsp3_err", 32'(rsp_err3), 32'(e[32]));
            end
        end
    end

    initial begin
        logic [31:0] saved;
        reset      = 1'b0;
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        req_we     = 1'b0;
        req_be     = 4'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready0", 32'(req_ready0), 32'd1);
        check("rst_valid0", 32'(rsp_valid0), 32'd0);
        check("rst_rdata0", rsp_rdata0, 32'h0);
        check("rst_err0", 32'(rsp_err0), 32'd0);
        check("rst_ready3", 32'(req_ready3), 32'd1);
        check("rst_valid3", 32'(rsp_valid3), 32'd0);
        check("rst_rdata3", rsp_rdata3, 32'h0);
        check("rst_err3", 32'(rsp_err3), 32'd0);

        // Zero wait states: store then load back to back.
        step(); req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
        step(); req(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        @(negedge clk);
        check("ws0_store_rsp", 32'(rsp_valid0), 32'd1);
        check("ws0_ready_resp", 32'(req_ready0), 32'd1);
        step(); idle();
        @(negedge clk);
        check("ws0_load_rsp", 32'(rsp_valid0), 32'd1);
        check("ws0_load_data", rsp_rdata0, 32'hDEADBEEF);
        @(negedge clk);
        check("ws0_pulse_end", 32'(rsp_valid0), 32'd0);
        check("ws0_rdata_hold", rsp_rdata0, 32'hDEADBEEF);

        // Single byte lane over an existing word.
        step(); req(0, 1'b1, 4'hF, 32'h10, 32'h11223344, 1'b0);
        step(); req(0, 1'b1, 4'b0010, 32'h11, 32'hA5A55AA5, 1'b0);
        step(); req(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        step(); idle();
        @(negedge clk);
        check("byte_merge", rsp_rdata0, 32'h11225A44);

`ifndef DMEM_ERR_CHECK_EN
        // Empty lane mask still responds and leaves memory alone; upper address bits alias.
        step(); req(0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
        step(); req(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        step(); req(0, 1'b1, 4'hF, 32'h1000_0004, 32'h5EED1234, 1'b0);
        step(); req(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0);
        step(); idle();
        @(negedge clk);
        check("alias_data", rsp_rdata0, 32'h5EED1234);
        check("alias_err", 32'(rsp_err0), 32'd0);
`else
        // Misaligned halfword is rejected and does not touch memory.
        step(); req(0, 1'b1, 4'hF, 32'h0, 32'h77665544, 1'b0);
        step(); req(0, 1'b1, 4'b0011, 32'h3, 32'hFFFFFFFF, 1'b1);
        @(negedge clk);
        step(); req(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("err_flag", 32'(rsp_err0), 32'd1);
        check("err_rdata", rsp_rdata0, 32'h0);
        step(); idle();
        @(negedge clk);
        check("err_mem_kept", rsp_rdata0, 32'h77665544);
`endif

        // Three wait states, with the next request held during WAIT.
        step(); req(3, 1'b1, 4'hF, 32'h20, 32'h0BADC0DE, 1'b0);
        step(); req(3, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ws3_ready_low", 32'(req_ready3), 32'd0);
            check("ws3_no_rsp", 32'(rsp_valid3), 32'd0);
        end
        @(negedge clk);
        check("ws3_rsp_lat", 32'(rsp_valid3), 32'd1);
        check("ws3_ready_resp", 32'(req_ready3), 32'd1);
        step(); idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("ws3_load_wait", 32'(rsp_valid3), 32'd0);
        end
        @(negedge clk);
        check("ws3_load_rsp", 32'(rsp_valid3), 32'd1);
        check("ws3_load_data", rsp_rdata3, 32'h0BADC0DE);

        // Reset during WAIT of a store aborts it.
        saved = m3[8];
        step(); req(3, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 1'b0);
        step(); idle();
        @(negedge clk);
        check("abort_in_wait", 32'(req_ready3), 32'd0);
        reset = 1'b0;
        void'(q3.pop_back());
        m3[8] = saved;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid3), 32'd0);
        end
        step(); req(3, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0);
        step(); idle();
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("abort_rsp", 32'(rsp_valid3), 32'd1);
        check("abort_mem_kept", rsp_rdata3, 32'h0BADC0DE);

        repeat (6) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q3_drained", 32'(q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
